// File: rtl/l4_perf_window_pkg.sv
// Shared definitions for the performance measurement-window controller:
// state encoding, default timer width and the registered output bundle.
package l4_perf_window_pkg;

  // Default width of the window-limit value and the window timer.
  localparam int TBITS_DEF = 16;

  // Controller state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Registered outputs toward the cycle counter and the status register.
  typedef struct packed {
    logic cnt_clr;
    logic cnt_en;
    logic busy;
    logic done;
    logic timed_out;
  } win_out_t;

  // True in the states where the window is armed or open.
  function automatic logic is_busy(input state_t s);
    return (s == ST_ARMED) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/l4_perf_wtimer.sv
// Window timer: TBITS up-counter with synchronous clear, count enable and a
// terminal flag that fires on the last allowed cycle of a limited window.
module l4_perf_wtimer
  import l4_perf_window_pkg::*;
#(
  parameter int TBITS = TBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [TBITS-1:0] limit,
  output logic             tc
);

  localparam logic [TBITS-1:0] ONE = TBITS'(1);

  logic [TBITS-1:0] cnt_q, cnt_d;

  // Clear wins over enable; with limit 0 the counter simply wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + ONE;
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Terminal compare: current cycle is the L-th enabled cycle (value L-1).
  assign tc = (limit != '0) && (cnt_q == (limit - ONE));

endmodule

// File: rtl/l4_perf_window.sv
// Measurement-window controller. Converts host arm/abort and datapath
// start/stop events into a count-clear pulse and count-enable for the
// downstream cycle counter, with an optional cycle limit and sticky status.
// All outputs are registered and decoded from the next state, so they line
// up with the state the FSM enters at each edge.
module l4_perf_window
  import l4_perf_window_pkg::*;
#(
  parameter int TBITS = TBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic             start_evt,
  input  logic             stop_evt,
  input  logic [TBITS-1:0] limit,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             timed_out
);

  state_t           state_q, state_d;
  win_out_t         out_q, out_d;
  logic [TBITS-1:0] limit_q, limit_d;

  logic arm_acc;      // arm accepted this cycle (IDLE/DONE, no abort)
  logic limit_hit;    // window closes on the limit this cycle
  logic tmr_tc;

  // Arm is only honoured when idle or finished; abort always overrides it.
  assign arm_acc   = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Stop on the limit cycle wins, so a timeout needs stop_evt low.
  assign limit_hit = (state_q == ST_RUN) && !abort && !stop_evt && tmr_tc;

  l4_perf_wtimer #(.TBITS(TBITS)) u_wtimer (
    .clk   (clk),
    .reset (reset),
    .clr   (arm_acc),
    .en    (state_q == ST_RUN),
    .limit (limit_q),
    .tc    (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (arm_acc) state_d = ST_ARMED;
        // stop_evt alone is ignored while waiting for the window to open.
        ST_ARMED: if (start_evt) state_d = stop_evt ? ST_DONE : ST_RUN;
        ST_RUN:   if (stop_evt || tmr_tc) state_d = ST_DONE;
        ST_DONE:  if (arm_acc) state_d = ST_ARMED;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode from the next state; timed_out is sticky only while DONE holds.
  always_comb begin
    out_d           = '0;
    out_d.cnt_clr   = arm_acc;
    out_d.cnt_en    = (state_d == ST_RUN);
    out_d.busy      = is_busy(state_d);
    out_d.done      = (state_d == ST_DONE);
    out_d.timed_out = limit_hit ||
                      ((state_q == ST_DONE) && (state_d == ST_DONE) && out_q.timed_out);
  end

  // Limit is captured only when an arm is accepted.
  always_comb begin
    limit_d = limit_q;
    if (arm_acc) limit_d = limit;
  end

  // Output and limit registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      limit_q <= '0;
    end else begin
      out_q   <= out_d;
      limit_q <= limit_d;
    end
  end

  assign cnt_clr   = out_q.cnt_clr;
  assign cnt_en    = out_q.cnt_en;
  assign busy      = out_q.busy;
  assign done      = out_q.done;
  assign timed_out = out_q.timed_out;

endmodule

// File: tb/tb_l4_perf_window.sv
// Self-checking bench for l4_perf_window: directed table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_l4_perf_window;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0, abort = 1'b0, start_evt = 1'b0, stop_evt = 1'b0;
  logic [15:0] limit = '0;
  logic        cnt_clr, cnt_en, busy, done, timed_out;

  int total = 0;
  int bad   = 0;

  l4_perf_window #(.TBITS(16)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .start_evt(start_evt), .stop_evt(stop_evt), .limit(limit),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy), .done(done),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: window bookkeeping with plain flags and an unbounded count.
  bit m_wait, m_win, m_fin, m_to, m_clr;
  int m_cnt, m_lim;

  function automatic logic [4:0] m_outs();
    return {m_clr, m_win, m_wait | m_win, m_fin, m_to};
  endfunction

  function automatic logic [4:0] dut_outs();
    return {cnt_clr, cnt_en, busy, done, timed_out};
  endfunction

  task automatic model_reset();
    m_wait = 0; m_win = 0; m_fin = 0; m_to = 0; m_clr = 0; m_cnt = 0; m_lim = 0;
  endtask

  task automatic model_step(input bit a, input bit ab, input bit st, input bit sp, input int lim);
    m_clr = 0;
    if (ab) begin
      m_wait = 0; m_win = 0; m_fin = 0; m_to = 0;
    end else if (m_wait) begin
      if (st) begin
        m_wait = 0;
        if (sp) m_fin = 1;
        else begin m_win = 1; m_cnt = 0; end
      end
    end else if (m_win) begin
      m_cnt++;                         // cycles the window has been open so far
      if (sp) begin
        m_win = 0; m_fin = 1;
      end else if (m_lim != 0 && m_cnt == m_lim) begin
        m_win = 0; m_fin = 1; m_to = 1;
      end
    end else if (a) begin
      m_wait = 1; m_fin = 0; m_to = 0; m_lim = lim; m_clr = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, model steps at posedge, compare at next negedge.
  task automatic cyc(input bit a, input bit ab, input bit st, input bit sp, input logic [15:0] lim);
    arm = a; abort = ab; start_evt = st; stop_evt = sp; limit = lim;
    @(posedge clk);
    model_step(a, ab, st, sp, int'(lim));
    @(negedge clk);
    chk("model", 32'(dut_outs()), 32'(m_outs()));
  endtask

  task automatic do_reset();
    arm = 0; abort = 0; start_evt = 0; stop_evt = 0; limit = '0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("reset_outs", 32'(dut_outs()), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          a, ab, st, sp;
    logic [15:0] lim;
    logic [4:0]  exp;   // {cnt_clr, cnt_en, busy, done, timed_out}
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_n, clr_n, en_first, en_last, clr_at, done_first;

    tbl[0]  = '{0,0,0,0,16'd0, 5'b00000};
    tbl[1]  = '{1,0,0,0,16'd2, 5'b10100};
    tbl[2]  = '{0,0,0,0,16'd0, 5'b00100};
    tbl[3]  = '{0,0,0,1,16'd0, 5'b00100};
    tbl[4]  = '{0,0,1,0,16'd0, 5'b01100};
    tbl[5]  = '{1,0,0,0,16'd7, 5'b01100};
    tbl[6]  = '{0,0,0,0,16'd0, 5'b00011};
    tbl[7]  = '{0,0,1,1,16'd0, 5'b00011};
    tbl[8]  = '{1,0,0,0,16'd0, 5'b10100};
    tbl[9]  = '{0,0,1,1,16'd0, 5'b00010};
    tbl[10] = '{1,1,0,0,16'd0, 5'b00000};
    tbl[11] = '{1,0,0,0,16'd0, 5'b10100};
    tbl[12] = '{0,0,1,0,16'd0, 5'b01100};
    tbl[13] = '{0,1,0,0,16'd0, 5'b00000};

    @(negedge clk);
    do_reset();
    @(negedge clk);
    chk("post_reset", 32'(dut_outs()), 32'(0));

    // Directed table
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].a, tbl[i].ab, tbl[i].st, tbl[i].sp, tbl[i].lim);
      chk($sformatf("tbl%0d", i), 32'(dut_outs()), 32'(tbl[i].exp));
    end

    // Arm at 10, start at 20, stop at 57, unlimited
    do_reset();
    en_n = 0; clr_n = 0; en_first = -1; en_last = -1; clr_at = -1; done_first = -1;
    for (int i = 0; i <= 60; i++) begin
      cyc(i == 10, 0, i == 20, i == 57, 16'd0);
      if (cnt_clr) begin clr_n++; clr_at = i + 1; end
      if (cnt_en) begin en_n++; if (en_first < 0) en_first = i + 1; en_last = i + 1; end
      if (done && done_first < 0) done_first = i + 1;
    end
    chk("tp1_clr_n", 32'(clr_n), 32'(1));
    chk("tp1_clr_at", 32'(clr_at), 32'(11));
    chk("tp1_en_n", 32'(en_n), 32'(37));
    chk("tp1_en_first", 32'(en_first), 32'(21));
    chk("tp1_en_last", 32'(en_last), 32'(57));
    chk("tp1_done_first", 32'(done_first), 32'(58));
    chk("tp1_to", 32'(timed_out), 32'(0));

    // limit=5, no stop: exactly 5 enabled cycles then timeout
    do_reset();
    en_n = 0; en_last = -1; done_first = -1;
    cyc(1, 0, 0, 0, 16'd5);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, i == 0, 0, 16'd0);
      if (cnt_en) begin en_n++; en_last = i; end
      if (done && done_first < 0) done_first = i;
    end
    chk("tp2_en_n", 32'(en_n), 32'(5));
    chk("tp2_done_next", 32'(done_first), 32'(en_last + 1));
    chk("tp2_to", 32'({done, timed_out}), 32'(2'b11));

    // limit=5, stop on the 5th enabled cycle: stop wins
    en_n = 0;
    cyc(1, 0, 0, 0, 16'd5);
    cyc(0, 0, 1, 0, 16'd0);
    if (cnt_en) en_n++;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 16'd0);
      if (cnt_en) en_n++;
    end
    cyc(0, 0, 0, 1, 16'd0);
    chk("tp3_en_n", 32'(en_n), 32'(5));
    chk("tp3_status", 32'({cnt_en, done, timed_out}), 32'(3'b010));

    // limit=1: single enabled cycle then timeout
    cyc(1, 0, 0, 0, 16'd1);
    cyc(0, 0, 1, 0, 16'd0);
    chk("lim1_en", 32'(cnt_en), 32'(1));
    cyc(0, 0, 0, 0, 16'd0);
    chk("lim1_to", 32'({cnt_en, done, timed_out}), 32'(3'b011));

    // start and stop together in ARMED: zero-length window
    en_n = 0;
    cyc(1, 0, 0, 0, 16'd3);
    if (cnt_en) en_n++;
    cyc(0, 0, 1, 1, 16'd0);
    if (cnt_en) en_n++;
    chk("tp4_en_n", 32'(en_n), 32'(0));
    chk("tp4_status", 32'({busy, done, timed_out}), 32'(3'b010));

    // abort together with arm during RUN
    cyc(1, 0, 0, 0, 16'd0);
    cyc(0, 0, 1, 0, 16'd0);
    cyc(0, 0, 0, 0, 16'd0);
    cyc(1, 1, 0, 0, 16'd9);
    chk("tp5_outs", 32'(dut_outs()), 32'(0));
    cyc(0, 0, 0, 0, 16'd0);
    chk("tp5_no_clr", 32'(cnt_clr), 32'(0));

    // asynchronous reset mid-RUN, then re-arm from DONE
    cyc(1, 0, 0, 0, 16'd0);
    cyc(0, 0, 1, 0, 16'd0);
    cyc(0, 0, 0, 0, 16'd0);
    chk("tp6_running", 32'(cnt_en), 32'(1));
    #2 reset = 1'b1;
    #1 chk("tp6_async_en", 32'(cnt_en), 32'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 16'd0);
    chk("tp6_idle", 32'(dut_outs()), 32'(0));
    cyc(1, 0, 0, 0, 16'd0);
    cyc(0, 0, 1, 0, 16'd0);
    cyc(0, 0, 0, 1, 16'd0);
    chk("tp6_done", 32'(done), 32'(1));
    cyc(1, 0, 0, 0, 16'd4);
    chk("tp6_rearm", 32'({cnt_clr, busy, done}), 32'(3'b110));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        logic [15:0] l;
        case ($urandom_range(3))
          0:       l = 16'd0;
          1:       l = 16'($urandom_range(1, 3));
          default: l = 16'($urandom_range(1, 14));
        endcase
        cyc($urandom_range(7) == 0, $urandom_range(59) == 0,
            $urandom_range(5) == 0, $urandom_range(9) == 0, l);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
